// File: rtl/tdc_readout_pkg.sv
// Shared constants for the TDC readout path: frame sync byte, FSM state
// encodings and the data-byte count helper used to size the serializer.
package tdc_readout_pkg;

    // First byte of every frame so the host can find word boundaries.
    localparam logic [7:0] TDC_SYNC_BYTE = 8'hA5;

    // Serializer FSM state encodings.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_BITS  = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    // Number of whole bytes needed to carry a data_w-bit result word.
    function automatic int tdc_num_bytes(input int data_w);
        return (data_w + 7) / 8;
    endfunction

endpackage

// File: rtl/tdc_fifo.sv
// Small synchronous FIFO for TDC result words. A write presented while full
// is still accepted when a read happens in the same cycle, because the read
// frees the slot being written.
module tdc_fifo
    import tdc_readout_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_rd,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_full,
    output logic              o_empty,
    output logic [LW-1:0]     o_level
);

    localparam logic [LW-1:0] FULL_COUNT = LW'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_count;

    logic w_full;
    logic w_empty;
    logic w_do_wr;
    logic w_do_rd;

    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == {LW{1'b0}});
    assign w_do_wr = i_wr & (~w_full | i_rd);
    assign w_do_rd = i_rd & ~w_empty;

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = r_count;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers and occupancy count, cleared to empty on reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {LW{1'b0}};
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/tdc_readout.sv
// TDC result readout: captures each result word on the rising edge of the
// done strobe into a FIFO and sends it to the host as an 8N1 UART frame made
// of a sync byte followed by the zero-extended word, most significant byte
// first, each byte LSB first on the wire.
module tdc_readout
    import tdc_readout_pkg::*;
#(
    parameter int DATA_W       = 24,
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic [DATA_W-1:0] iData,
    input  logic              iValid,
    output logic              oTx,
    output logic              oBusy,
    output logic              oOverflow,
    output logic [LVL_W-1:0]  oLevel
);

    localparam int NB         = tdc_num_bytes(DATA_W);
    localparam int WORD_W     = NB * 8;
    localparam int CNT_W      = $clog2(CLKS_PER_BIT);
    localparam int BYTE_IDX_W = $clog2(NB + 1);

    localparam logic [CNT_W-1:0]      CNT_LAST      = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_IDX_W-1:0] BYTE_IDX_LAST = BYTE_IDX_W'(NB);

    logic                  r_prev_valid;
    logic                  r_overflow;
    logic [2:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [2:0]            r_bit_idx;
    logic [BYTE_IDX_W-1:0] r_byte_idx;
    logic [7:0]            r_byte;
    logic [WORD_W-1:0]     r_word;
    logic                  r_tx;

    logic                  w_write;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [DATA_W-1:0]     w_fifo_rdata;
    logic [LVL_W-1:0]      w_fifo_level;
    logic [WORD_W-1:0]     w_head_word;
    logic                  w_bit_end;

    // One write per rising edge of the strobe, however long it is held.
    assign w_write     = iValid & ~r_prev_valid;
    assign w_pop       = (r_state == ST_LOAD);
    assign w_drop      = w_write & w_fifo_full & ~w_pop;
    assign w_head_word = WORD_W'(w_fifo_rdata);
    assign w_bit_end   = (r_cnt == CNT_LAST);

    tdc_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (iClk),
        .i_rst   (iRst),
        .i_wr    (w_write),
        .i_wdata (iData),
        .i_rd    (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (w_fifo_level)
    );

    // Strobe history for edge detection and the sticky overflow flag.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_prev_valid <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_prev_valid <= iValid;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Serializer FSM with baud counter; the TX line is registered and set
    // together with the state it belongs to.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= {CNT_W{1'b0}};
            r_bit_idx  <= 3'd0;
            r_byte_idx <= {BYTE_IDX_W{1'b0}};
            r_byte     <= 8'h00;
            r_word     <= {WORD_W{1'b0}};
            r_tx       <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx  <= 1'b1;
                    r_cnt <= {CNT_W{1'b0}};
                    if (!w_fifo_empty) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_word     <= w_head_word;
                    r_byte     <= TDC_SYNC_BYTE;
                    r_byte_idx <= {BYTE_IDX_W{1'b0}};
                    r_bit_idx  <= 3'd0;
                    r_cnt      <= {CNT_W{1'b0}};
                    r_tx       <= 1'b0;
                    r_state    <= ST_START;
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_cnt     <= {CNT_W{1'b0}};
                        r_bit_idx <= 3'd0;
                        r_tx      <= r_byte[0];
                        r_state   <= ST_BITS;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_BITS: begin
                    if (w_bit_end) begin
                        r_cnt <= {CNT_W{1'b0}};
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_byte[r_bit_idx + 3'd1];
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= {CNT_W{1'b0}};
                        if (r_byte_idx != BYTE_IDX_LAST) begin
                            // Next data byte comes off the top of the word.
                            r_byte_idx <= r_byte_idx + BYTE_IDX_W'(1);
                            r_byte     <= r_word[WORD_W-1 -: 8];
                            r_word     <= r_word << 8;
                            r_tx       <= 1'b0;
                            r_state    <= ST_START;
                        end else if (!w_fifo_empty) begin
                            r_tx    <= 1'b1;
                            r_state <= ST_LOAD;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt   <= {CNT_W{1'b0}};
                    r_tx    <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign oTx       = r_tx;
    assign oOverflow = r_overflow;
    assign oLevel    = w_fifo_level;
    assign oBusy     = (r_state != ST_IDLE) | (w_fifo_level != {LVL_W{1'b0}});

endmodule
